// File: rtl/hzd_unit.sv
// rtl/hzd_unit.sv - pipeline hazard detection and forwarding control
// Compares ID sources against every in-flight destination; stalls or forwards.
module hzd_unit #(
    parameter int NSTG  = 3,
    parameter int NRS   = 2,
    parameter int FW_EN = 1,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [5*NRS-1:0]     id_rs,
    input  logic [NRS-1:0]       id_rs_use,
    input  logic                 id_late,
    input  logic [5*NSTG-1:0]    stg_rd,
    input  logic [NSTG-1:0]      stg_wr,
    input  logic [NSTG-1:0]      stg_rdy,
    input  logic                 stall_ext,
    output logic                 stall_fe,
    output logic                 bubble,
    output logic [NRS-1:0]       fw_en,
    output logic [NRS*NSTG-1:0]  fw_sel,
    output logic [CNTW-1:0]      hzd_cnt
);

    localparam logic FWD = (FW_EN != 0);

    logic [NRS-1:0][NSTG-1:0] match;
    logic [NRS-1:0][NSTG-1:0] win_oh;
    logic [NRS-1:0]           any_m;
    logic [NRS-1:0]           unres;
    logic                     haz;

    logic [NRS-1:0]           fw_en_d, fw_en_q;
    logic [NRS*NSTG-1:0]      fw_sel_d, fw_sel_q;
    logic [CNTW-1:0]          hzd_cnt_d, hzd_cnt_q;

    always_comb begin
        match  = '0;
        win_oh = '0;
        any_m  = '0;
        unres  = '0;
        for (int k = 0; k < NRS; k++) begin
            for (int s = 0; s < NSTG; s++) begin
                match[k][s] = id_valid & id_rs_use[k] & (id_rs[5*k +: 5] != 5'd0) &
                              stg_wr[s] & (stg_rd[5*s +: 5] == id_rs[5*k +: 5]);
            end
            // Isolate the lowest set bit: the youngest producer wins.
            win_oh[k] = match[k] & (~match[k] + NSTG'(1));
            any_m[k]  = |match[k];
            unres[k]  = any_m[k] & ~(FWD & ~id_late & (|(win_oh[k] & stg_rdy)));
        end
        haz = |unres;
    end

    assign stall_fe = ~rst_n | stall_ext | haz;
    assign bubble   = haz & ~stall_ext & rst_n;

    always_comb begin
        fw_en_d   = fw_en_q;
        fw_sel_d  = fw_sel_q;
        hzd_cnt_d = hzd_cnt_q;
        if (!stall_ext) begin
            if (haz || !id_valid) begin
                fw_en_d  = '0;
                fw_sel_d = '0;
            end else begin
                for (int k = 0; k < NRS; k++) begin
                    fw_en_d[k]                = any_m[k];
                    fw_sel_d[NSTG*k +: NSTG]  = win_oh[k];
                end
            end
            if (haz && (hzd_cnt_q != {CNTW{1'b1}})) begin
                hzd_cnt_d = hzd_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_en_q   <= '0;
            fw_sel_q  <= '0;
            hzd_cnt_q <= '0;
        end else begin
            fw_en_q   <= fw_en_d;
            fw_sel_q  <= fw_sel_d;
            hzd_cnt_q <= hzd_cnt_d;
        end
    end

    assign fw_en   = fw_en_q;
    assign fw_sel  = fw_sel_q;
    assign hzd_cnt = hzd_cnt_q;

endmodule

// File: tb/tb_hzd_unit.sv
// tb/tb_hzd_unit.sv - scoreboard bench for hzd_unit
// Two instances share stimulus: forwarding 16-bit counter, and no-forwarding 4-bit counter.
module tb_hzd_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_use;
    logic        id_late;
    logic [14:0] stg_rd;
    logic [2:0]  stg_wr;
    logic [2:0]  stg_rdy;
    logic        stall_ext;

    logic        stall_fe_a, bubble_a, stall_fe_b, bubble_b;
    logic [1:0]  fw_en_a, fw_en_b;
    logic [5:0]  fw_sel_a, fw_sel_b;
    logic [15:0] hzd_cnt_a;
    logic [3:0]  hzd_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hzd_unit #(.NSTG(3), .NRS(2), .FW_EN(1), .CNTW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_use(id_rs_use), .id_late(id_late), .stg_rd(stg_rd), .stg_wr(stg_wr),
        .stg_rdy(stg_rdy), .stall_ext(stall_ext), .stall_fe(stall_fe_a),
        .bubble(bubble_a), .fw_en(fw_en_a), .fw_sel(fw_sel_a), .hzd_cnt(hzd_cnt_a)
    );

    hzd_unit #(.NSTG(3), .NRS(2), .FW_EN(0), .CNTW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_use(id_rs_use), .id_late(id_late), .stg_rd(stg_rd), .stg_wr(stg_wr),
        .stg_rdy(stg_rdy), .stall_ext(stall_ext), .stall_fe(stall_fe_b),
        .bubble(bubble_b), .fw_en(fw_en_b), .fw_sel(fw_sel_b), .hzd_cnt(hzd_cnt_b)
    );

    typedef struct {
        int          idx;
        logic        sa, ba;
        logic [1:0]  fea;
        logic [5:0]  fsa;
        logic [15:0] ca;
        logic        sb, bb;
        logic [1:0]  feb;
        logic [5:0]  fsb;
        logic [3:0]  cb;
    } exp_t;

    exp_t        sb_q[$];
    int          vec_idx = 0;
    logic [15:0] cnt_a = '0;
    logic [3:0]  cnt_b = '0;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stall_fe_a", e.idx, {15'd0, stall_fe_a}, {15'd0, e.sa});
            chk("bubble_a",   e.idx, {15'd0, bubble_a},   {15'd0, e.ba});
            chk("fw_en_a",    e.idx, {14'd0, fw_en_a},    {14'd0, e.fea});
            chk("fw_sel_a",   e.idx, {10'd0, fw_sel_a},   {10'd0, e.fsa});
            chk("hzd_cnt_a",  e.idx, hzd_cnt_a,           e.ca);
            chk("stall_fe_b", e.idx, {15'd0, stall_fe_b}, {15'd0, e.sb});
            chk("bubble_b",   e.idx, {15'd0, bubble_b},   {15'd0, e.bb});
            chk("fw_en_b",    e.idx, {14'd0, fw_en_b},    {14'd0, e.feb});
            chk("fw_sel_b",   e.idx, {10'd0, fw_sel_b},   {10'd0, e.fsb});
            chk("hzd_cnt_b",  e.idx, {12'd0, hzd_cnt_b},  {12'd0, e.cb});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v, input logic [9:0] rs, input logic [1:0] use_m,
                         input logic late, input logic [14:0] rd, input logic [2:0] wr,
                         input logic [2:0] rdy, input logic sx,
                         input logic sa, input logic ba, input logic [1:0] fea, input logic [5:0] fsa,
                         input logic sb, input logic bb, input logic [1:0] feb, input logic [5:0] fsb);
        exp_t e;
        id_valid  = v;
        id_rs     = rs;
        id_rs_use = use_m;
        id_late   = late;
        stg_rd    = rd;
        stg_wr    = wr;
        stg_rdy   = rdy;
        stall_ext = sx;
        e.idx = vec_idx; e.sa = sa; e.ba = ba; e.fea = fea; e.fsa = fsa; e.ca = cnt_a;
        e.sb = sb; e.bb = bb; e.feb = feb; e.fsb = fsb; e.cb = cnt_b;
        sb_q.push_back(e);
        vec_idx++;
        if (ba && cnt_a != 16'hFFFF) cnt_a++;
        if (bb && cnt_b != 4'hF) cnt_b++;
    endtask

    task automatic idle(input logic [1:0] fea, input logic [5:0] fsa);
        apply(0, 10'd0, 2'b00, 0, 15'd0, 3'b000, 3'b000, 0,  0, 0, fea, fsa,  0, 0, 2'b00, 6'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = '0; id_rs_use = '0; id_late = 0;
        stg_rd = '0; stg_wr = '0; stg_rdy = '0; stall_ext = 0;
        step();
        // V0: reset state
        apply(0, 10'd0, 2'b00, 0, 15'd0, 3'b000, 3'b000, 0,  1, 0, 2'b00, 6'd0,  1, 0, 2'b00, 6'd0);
        step();
        rst_n = 1'b1;
        // V1: ALU x5 in EX, ID rs1=x5
        apply(1, {5'd0, 5'd5}, 2'b01, 0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b001, 0,  0, 0, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        idle(2'b01, 6'b000_001);
        step();
        // V3/V4: load-use on rs2=x7
        apply(1, {5'd7, 5'd0}, 2'b10, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b000, 0,  1, 1, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        apply(1, {5'd7, 5'd0}, 2'b10, 0, {5'd0, 5'd7, 5'd0}, 3'b010, 3'b010, 0,  0, 0, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        idle(2'b10, 6'b010_000);
        step();
        // V6: x9 in EX and WB, x0 operand against stg_rd=0
        apply(1, {5'd0, 5'd9}, 2'b11, 0, {5'd9, 5'd0, 5'd9}, 3'b111, 3'b111, 0,  0, 0, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        idle(2'b01, 6'b000_001);
        step();
        // V8-V10: branch reads x3 produced in MEM, then WB, then gone
        apply(1, {5'd0, 5'd3}, 2'b01, 1, {5'd0, 5'd3, 5'd0}, 3'b010, 3'b010, 0,  1, 1, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        apply(1, {5'd0, 5'd3}, 2'b01, 1, {5'd3, 5'd0, 5'd0}, 3'b100, 3'b100, 0,  1, 1, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        apply(1, {5'd0, 5'd3}, 2'b01, 1, 15'd0, 3'b000, 3'b000, 0,  0, 0, 2'b00, 6'd0,  0, 0, 2'b00, 6'd0);
        step();
        idle(2'b00, 6'd0);
        step();
        // V12-V14: same producer pattern on an ALU op
        apply(1, {5'd0, 5'd3}, 2'b01, 0, {5'd0, 5'd3, 5'd0}, 3'b010, 3'b010, 0,  0, 0, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        apply(1, {5'd0, 5'd3}, 2'b01, 0, {5'd3, 5'd0, 5'd0}, 3'b100, 3'b100, 0,  0, 0, 2'b01, 6'b000_010,  1, 1, 2'b00, 6'd0);
        step();
        apply(1, {5'd0, 5'd3}, 2'b01, 0, 15'd0, 3'b000, 3'b000, 0,  0, 0, 2'b01, 6'b000_100,  0, 0, 2'b00, 6'd0);
        step();
        // V15: forwarding issue so the frozen forward registers are non-zero
        apply(1, {5'd0, 5'd5}, 2'b01, 0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b001, 0,  0, 0, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
        step();
        // V16-V19: load hazard under external stall
        for (int i = 0; i < 4; i++) begin
            apply(1, {5'd7, 5'd0}, 2'b10, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b000, 1,  1, 0, 2'b01, 6'b000_001,  1, 0, 2'b00, 6'd0);
            step();
        end
        // V20: asynchronous reset mid-stall, checked before any clock edge
        cnt_a = '0;
        cnt_b = '0;
        apply(1, {5'd7, 5'd0}, 2'b10, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b000, 1,  1, 0, 2'b00, 6'd0,  1, 0, 2'b00, 6'd0);
        #2 rst_n = 1'b0;
        step();
        apply(1, {5'd7, 5'd0}, 2'b10, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b000, 0,  1, 0, 2'b00, 6'd0,  1, 0, 2'b00, 6'd0);
        step();
        rst_n = 1'b1;
        // V22-V41: persistent hazard; the 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            apply(1, {5'd7, 5'd0}, 2'b10, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b000, 0,  1, 1, 2'b00, 6'd0,  1, 1, 2'b00, 6'd0);
            step();
        end
        idle(2'b00, 6'd0);
        step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", vec_idx, 16'(sb_q.size()), 16'd0);
        chk("final_cnt_a", vec_idx, hzd_cnt_a, 16'd20);
        chk("final_cnt_b", vec_idx, {12'd0, hzd_cnt_b}, 16'd15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, vectors issued %0d", vec_idx);
        $fatal(1);
    end

endmodule

// File: doc/hzd_unit.md
# hzd_unit

Parametrised pipeline hazard and forwarding controller for the rv6 hart, generalising the fixed EX/MEM/WB hazard logic to an arbitrary number of result-producing back-end stages and source operands. Each cycle it compares the ID-stage source registers against every in-flight destination register. It then decides whether to issue with forwarding or to hold the front end and inject a bubble into EX. It also provides registered forward-select controls for the EX operand muxes and a saturating hazard-stall performance counter.

## Interface
- NSTG, 3, number of back-end stages carrying a destination register; stage 0 = EX, NSTG-1 = last (WB); legal 1..8
- NRS, 2, number of source operands per instruction; legal 1..3
- FW_EN, 1, 1 = forwarding enabled; 0 = every hazard stalls until the producer leaves the pipeline
- CNTW, 16, width of hazard-stall counter
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  5*NRS  source register of operand k at [5k+4:5k]
- id_rs_use  in  NRS  operand k reads the register file (0 for PC/immediate operands)
- id_late  in  1  ID instruction consumes operands in ID (branch, jalr, store); forwarding is unusable for it
- stg_rd  in  5*NSTG  destination register of stage s at [5s+4:5s]
- stg_wr  in  NSTG  stage s holds an instruction that writes rd
- stg_rdy  in  NSTG  stage s result is available at its output register (0 e.g. for a load still in EX)
- stall_ext  in  1  external stall (imem/dmem/hmem, pending AMO); freezes the whole pipeline
- stall_fe  out  1  hold IF/PD/ID
- bubble  out  1  load a NOP into EX instead of the ID instruction
- fw_en  out  NRS  operand k in EX takes a forwarded value
- fw_sel  out  NRS*NSTG  one-hot per operand at [NSTG*k+NSTG-1:NSTG*k]; bit s = output register of stage s
- hzd_cnt  out  CNTW  saturating count of hazard-stall cycles

## Operation
- match[k][s] = id_valid & id_rs_use[k] & (id_rs[k] != 0) & stg_wr[s] & (stg_rd[s] == id_rs[k]).
- Winner w[k] = the lowest s with match[k][s] set (the youngest producer). Older matches are ignored.
- Operand k is resolved if it has no match, or if FW_EN & !id_late & stg_rdy[w[k]].
- haz = OR over k of unresolved operands. Operands are evaluated independently and may forward from different stages.
- If id_late, any match is unresolved; the instruction stalls until no stage matches.
- With FW_EN=0, any match is unresolved.
- stall_fe = !rst_n | stall_ext | haz.
- bubble = haz & !stall_ext & rst_n. During stall_ext no bubble is inserted; the back end is frozen.
- Forward registers, updated at posedge clk:
  - If stall_ext: hold.
  - Else if haz or !id_valid: fw_en <= 0 and fw_sel <= 0.
  - Else for each k: fw_en[k] <= match-any[k], and fw_sel[k] <= one-hot(w[k]), or 0 if no match.
- Meaning of fw_sel bit s: the producer that sat in stage s at issue is, in the following cycle, in the output register of stage s. The datapath mux selects that register.
- hzd_cnt increments when haz & !stall_ext, and saturates at all-ones (no wrap).

## Timing
- Reset (rst_n low, asynchronous): fw_en=0, fw_sel=0, hzd_cnt=0. While rst_n is low, stall_fe=1 and bubble=0.
- Reset deassertion is synchronised externally; the first evaluation happens on the first posedge with rst_n high.
- stall_fe and bubble are combinational from inputs in the same cycle; no added latency.
- fw_en and fw_sel take 1-cycle latency: they are valid in the cycle the instruction occupies EX.
- Load-use with NSTG=3, a load in EX (stg_rdy[0]=0) and a dependent ALU op in ID:
  - 1 bubble cycle.
  - Next cycle the load is in MEM with rdy=1; the op issues with fw_sel=3'b010.
- A hazard clears without forwarding once the last match leaves stage NSTG-1. The register file writes at that edge, so the ID instruction reads the correct value the next cycle.
- stall_ext asserted mid-hazard: bubble drops to 0, and the forward registers and counter hold.
- Reset mid-stall discards all state.

## Test plan
- NSTG=3, FW_EN=1: ALU writes x5 in EX (rdy=1); ID add reads rs1=x5 -> no stall; next cycle fw_en=2'b01, fw_sel[2:0]=3'b001.
- Load x7 in EX (rdy=0), ID reads rs2=x7 -> stall_fe=1, bubble=1 for 1 cycle, hzd_cnt=1. Then with the load in MEM (rdy=1) -> issue with fw_en=2'b10, fw_sel[5:3]=3'b010.
- x9 written in both EX and WB, ID reads x9 -> winner is EX, fw_sel=3'b001. Also: rs=x0 matched by stg_rd=0 -> no hazard.
- id_late=1 (branch) reading x3 written in MEM -> stall 2 cycles, until x3 leaves WB, then issue with fw_en=0. Repeat with FW_EN=0 on an ALU op -> same stall pattern.
- Hazard active, then stall_ext=1 for 4 cycles -> bubble=0, stall_fe=1, hzd_cnt and fw_* frozen. Assert rst_n=0 mid-stall -> outputs reset immediately, without waiting for clk.
- CNTW=4: hold the hazard for 20 cycles -> hzd_cnt saturates at 15.
